pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage RV32IM pipeline. It owns the hold/bubble controls of
//  PC, IF_ID_reg, ID_EX_reg and EX_MEM_reg. It resolves load-use hazards and taken branch/jump redirects.
//  It holds multi-cycle M-extension ops (MUL/DIV/REM) in EX for a fixed latency via a small FSM + counter.
// PARAMETERS
//  MUL_CYCLES   2   total cycles a MUL* op occupies EX (>=1)
//  DIV_CYCLES   33  total cycles a DIV*/REM* op occupies EX (>=1)
//  CNT_W        6   width of the internal busy counter; must hold max(MUL_CYCLES,DIV_CYCLES)-2
// PORTS
//  CLK                  in   1   clock; all state updates on rising edge
//  RESET                in   1   reset: synchronous, active-high
//  ID_RS1, ID_RS2       in   5   source register addresses of the instruction in ID
//  ID_USES_RS1/RS2      in   1   1 = ID instruction actually reads that source
//  EX_DEST_REG          in   5   destination register of the instruction in EX (ID_EX_reg OUT_DEST_REG)
//  EX_MEM_READ          in   2   ID_EX_reg OUT_MEM_READ; non-zero = load in EX
//  EX_REG_WRITE_ENABLE  in   1   ID_EX_reg OUT_REG_WRITE_ENABLE
//  EX_MULDIV            in   2   00 none, 01 MUL-class, 10 DIV/REM-class, 11 reserved (treated as 00)
//  EX_BRANCH_TAKEN      in   1   branch/jump in EX resolved taken (redirect this cycle)
//  PC_STALL             out  1   hold PC
//  IF_ID_STALL          out  1   hold IF_ID_reg
//  IF_ID_FLUSH          out  1   load NOP into IF_ID_reg at next edge
//  ID_EX_STALL          out  1   hold ID_EX_reg
//  ID_EX_FLUSH          out  1   load bubble (all controls 0) into ID_EX_reg at next edge
//  EX_MEM_FLUSH         out  1   load bubble into EX_MEM_reg at next edge
//  MULDIV_BUSY          out  1   multi-cycle op held in EX this cycle
//  STALL_CYCLES         out  32  count of cycles with PC_STALL=1; saturates at 32'hFFFF_FFFF
// BEHAVIOUR
//  Reset: at a CLK edge with RESET=1: state<=RUN, cnt<=0, STALL_CYCLES<=0.
//   While RESET=1, all 1-bit outputs are forced 0 combinationally.
//  load_use = EX_MEM_READ!=0 & EX_REG_WRITE_ENABLE & EX_DEST_REG!=0 &
//   ((ID_USES_RS1 & ID_RS1==EX_DEST_REG) | (ID_USES_RS2 & ID_RS2==EX_DEST_REG)).
//  md_lat = MUL_CYCLES for 01, DIV_CYCLES for 10. md_req = EX_MULDIV in {01,10} & md_lat>1.
//  FSM states: RUN, MD_BUSY.
//   RUN, md_req: assert PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_FLUSH and MULDIV_BUSY.
//    Next state MD_BUSY; cnt<=md_lat-2.
//   MD_BUSY, cnt!=0: same four stall/flush outputs + MULDIV_BUSY asserted; cnt<=cnt-1.
//   MD_BUSY, cnt==0: no stall; instruction advances at this edge; next state RUN.
//   => M op occupies EX exactly md_lat cycles with md_lat-1 stall cycles; EX_MEM gets md_lat-1 bubbles.
//   md_lat==1: op passes with no stall, FSM stays RUN.
//  RUN, load_use (and not EX_BRANCH_TAKEN): PC_STALL=IF_ID_STALL=1, ID_EX_FLUSH=1 for exactly one cycle.
//   The hazard clears next cycle as the load moves to MEM. No state change.
//  EX_BRANCH_TAKEN (RUN only): IF_ID_FLUSH=ID_EX_FLUSH=1, no stalls, one cycle.
//   It takes priority over load_use, since the hazarding ID instruction is squashed.
//  Mutual exclusion: md_req with load_use or branch is impossible (one instruction in EX).
//   If seen, priority is md_req > branch > load_use.
//  In MD_BUSY, EX_BRANCH_TAKEN and load_use are ignored.
//  Stall and flush of the same register are never asserted together.
//  Reset mid-MD_BUSY: outputs drop to 0 immediately; FSM returns to RUN at that edge.
//  STALL_CYCLES increments on each edge where PC_STALL=1 (and RESET=0).
// TESTING
//  1 Reset: RESET=1 for 2 cycles, md_req driven -> all outs 0, STALL_CYCLES=0, state RUN after release.
//  2 Load-use: EX load x5 (MEM_READ=01, WE=1), ID RS1=5 used -> PC/IF_ID stall + ID_EX_FLUSH for 1 cycle.
//    STALL_CYCLES=1 afterwards. Same with EX_DEST_REG=0 -> no stall.
//  3 MUL: EX_MULDIV=01 held while stalled -> MULDIV_BUSY high exactly 1 cycle, EX_MEM_FLUSH 1 cycle.
//  4 DIV: EX_MULDIV=10 -> stalls exactly 32 consecutive cycles, drop on 33rd; STALL_CYCLES=32.
//    The next instruction (EX_MULDIV=00) causes no re-trigger.
//  5 Branch vs load-use: EX_BRANCH_TAKEN=1 with load_use true -> IF_ID_FLUSH=ID_EX_FLUSH=1, PC_STALL=0.
//  6 RESET asserted at DIV cycle 10 -> outputs 0 that cycle; RUN next.
//    A new EX_MULDIV=01 then restarts with MUL timing.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32IM pipeline: load-use interlock,
// taken-branch squash, and fixed-latency hold of multi-cycle MUL/DIV ops in EX.
module pipeline_hazard_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 6
)(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [4:0]  ID_RS1,
  input  logic [4:0]  ID_RS2,
  input  logic        ID_USES_RS1,
  input  logic        ID_USES_RS2,
  input  logic [4:0]  EX_DEST_REG,
  input  logic [1:0]  EX_MEM_READ,
  input  logic        EX_REG_WRITE_ENABLE,
  input  logic [1:0]  EX_MULDIV,
  input  logic        EX_BRANCH_TAKEN,
  output logic        PC_STALL,
  output logic        IF_ID_STALL,
  output logic        IF_ID_FLUSH,
  output logic        ID_EX_STALL,
  output logic        ID_EX_FLUSH,
  output logic        EX_MEM_FLUSH,
  output logic        MULDIV_BUSY,
  output logic [31:0] STALL_CYCLES
);
  typedef enum logic {RUN, MD_BUSY} state_t;

  // Counter preload is latency-2: the RUN cycle and the final release cycle are not counted.
  localparam bit              MUL_MC = (MUL_CYCLES > 1);
  localparam bit              DIV_MC = (DIV_CYCLES > 1);
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_MC ? MUL_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_MC ? DIV_CYCLES - 2 : 0);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [31:0]        r_stall_cycles;
  logic               w_load_use, w_md_req;
  logic [CNT_W-1:0]   w_md_ld;
  logic               w_pc_stall, w_if_id_stall, w_if_id_flush;
  logic               w_id_ex_stall, w_id_ex_flush, w_ex_mem_flush, w_busy;

  assign w_load_use = (EX_MEM_READ != 2'b00) && EX_REG_WRITE_ENABLE && (EX_DEST_REG != 5'd0) &&
                      ((ID_USES_RS1 && (ID_RS1 == EX_DEST_REG)) ||
                       (ID_USES_RS2 && (ID_RS2 == EX_DEST_REG)));
  assign w_md_req   = ((EX_MULDIV == 2'b01) && MUL_MC) || ((EX_MULDIV == 2'b10) && DIV_MC);
  assign w_md_ld    = (EX_MULDIV == 2'b10) ? DIV_LD : MUL_LD;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_pc_stall     = 1'b0;
    w_if_id_stall  = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_stall  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_flush = 1'b0;
    w_busy         = 1'b0;
    case (r_state)
      RUN: begin
        if (w_md_req) begin
          w_pc_stall     = 1'b1;
          w_if_id_stall  = 1'b1;
          w_id_ex_stall  = 1'b1;
          w_ex_mem_flush = 1'b1;
          w_busy         = 1'b1;
          w_state_nxt    = MD_BUSY;
          w_cnt_nxt      = w_md_ld;
        end else if (EX_BRANCH_TAKEN) begin
          // Squashing the ID instruction also removes any load-use hazard it had.
          w_if_id_flush  = 1'b1;
          w_id_ex_flush  = 1'b1;
        end else if (w_load_use) begin
          w_pc_stall     = 1'b1;
          w_if_id_stall  = 1'b1;
          w_id_ex_flush  = 1'b1;
        end
      end
      MD_BUSY: begin
        if (r_cnt != '0) begin
          w_pc_stall     = 1'b1;
          w_if_id_stall  = 1'b1;
          w_id_ex_stall  = 1'b1;
          w_ex_mem_flush = 1'b1;
          w_busy         = 1'b1;
          w_cnt_nxt      = r_cnt - CNT_W'(1);
        end else begin
          w_state_nxt    = RUN;
        end
      end
    endcase
  end

  assign PC_STALL     = w_pc_stall     & ~RESET;
  assign IF_ID_STALL  = w_if_id_stall  & ~RESET;
  assign IF_ID_FLUSH  = w_if_id_flush  & ~RESET;
  assign ID_EX_STALL  = w_id_ex_stall  & ~RESET;
  assign ID_EX_FLUSH  = w_id_ex_flush  & ~RESET;
  assign EX_MEM_FLUSH = w_ex_mem_flush & ~RESET;
  assign MULDIV_BUSY  = w_busy         & ~RESET;
  assign STALL_CYCLES = r_stall_cycles;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state        <= RUN;
      r_cnt          <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_pc_stall && (r_stall_cycles != 32'hFFFF_FFFF))
        r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end
endmodule
